// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory behind an enable/ready request
// port with a fixed-latency, one-cycle valid response.
//
// Handshake: a request is accepted at a rising edge where enable=1 and
// ready=1 (ready is high only in IDLE). Enable is ignored while busy.
// The response appears as valid=1 for exactly one cycle, LATENCY cycles
// after the acceptance cycle (acceptance cycle = cycle 0).
//
// Optional build macro DATA_MEM_RESPONDER_ERR_CHECK_EN adds an err output and
// flags misaligned or out-of-range addresses instead of aliasing them.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cmd,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  mask,
  output logic        ready,
  output logic        valid,
  output logic [31:0] load_data,
`ifdef DATA_MEM_RESPONDER_ERR_CHECK_EN
  output logic        err,
`endif
  output logic [1:0]  state_dbg
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [3:0]      cnt;
  logic [3:0]      cnt_n;
  logic            accept;
  logic            enter_resp;

  // Request context held through WAIT/RESP. The write itself is committed at
  // the acceptance edge, so only the type, word index and error flag persist.
  logic            cmd_q;
  logic [AW-1:0]   idx_q;
  logic            err_q;

  // Request context as seen at the RESP-entry edge; with LATENCY=1 that edge
  // is the acceptance edge itself, so the live inputs are used.
  logic            req_cmd;
  logic [AW-1:0]   req_idx;
  logic            req_err;

  logic [AW-1:0]   addr_idx;
  logic            addr_err;

  logic [31:0]     mem [DEPTH_WORDS];

  assign addr_idx = addr[AW+1:2];

`ifdef DATA_MEM_RESPONDER_ERR_CHECK_EN
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
  // Misaligned or beyond the array: no access, err with the response.
  assign addr_err = (addr[1:0] != 2'b00) || ({1'b0, addr} >= BYTE_LIMIT);
  assign err      = valid & err_q;
`else
  // Byte offset and upper bits are ignored: addresses alias modulo the array.
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
`endif

  assign req_cmd = accept ? cmd      : cmd_q;
  assign req_idx = accept ? addr_idx : idx_q;
  assign req_err = accept ? addr_err : err_q;

  // Next-state, latency counter and acceptance decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          accept  = 1'b1;
          cnt_n   = LAT_M1;
          state_n = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // RESP is always left after one cycle, so it is only ever a next state on entry.
  assign enter_resp = (state_n == RESP);
  assign ready      = (state == IDLE);
  assign valid      = (state == RESP);
  assign state_dbg  = state;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Capture request context at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q <= 1'b0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      cmd_q <= cmd;
      idx_q <= addr_idx;
      err_q <= addr_err;
    end
  end

  // Response data: loaded on read entry to RESP, zeroed on error, else held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_data <= 32'd0;
    end else if (enter_resp) begin
      if (req_err)       load_data <= 32'd0;
      else if (!req_cmd) load_data <= mem[req_idx];
    end
  end

  // Byte-masked write committed at the acceptance edge; array is never reset.
  always_ff @(posedge clk) begin
    if (rst && accept && cmd && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[addr_idx][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
// Inputs change and outputs are sampled on the falling edge.
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  mask;
  logic        ready;
  logic        valid;
  logic [31:0] load_data;
  logic [1:0]  state_dbg;
`ifdef DATA_MEM_RESPONDER_ERR_CHECK_EN
  logic        err;
`endif
  logic        last_err;

  int checks;
  int errors;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cmd       (cmd),
    .addr      (addr),
    .write_data(write_data),
    .mask      (mask),
    .ready     (ready),
    .valid     (valid),
    .load_data (load_data),
`ifdef DATA_MEM_RESPONDER_ERR_CHECK_EN
    .err       (err),
`endif
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one request from a falling edge; returns cycles until valid
  // (acceptance cycle counts as 0) and the load_data seen with valid.
  task automatic do_req(input logic c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, output int lat, output logic [31:0] ld);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd = c; addr = a; write_data = wd; mask = m; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    lat = 1;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ld = load_data;
`ifdef DATA_MEM_RESPONDER_ERR_CHECK_EN
    last_err = err;
`else
    last_err = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data: got %h expected 00000000", load_data); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] ld;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, ld);
    checks++; if (lat != LAT) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (ld !== 32'd0) begin errors++; $display("FAIL wr_load_data_held: got %h expected 00000000", ld); end
    checks++; if (valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL wr_one_cycle_valid: got valid=%b ready=%b expected valid=0 ready=1", valid, ready); end
    do_req(1'b0, 32'h10, 32'h0, 4'b0000, lat, ld);
    checks++; if (lat != LAT) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (ld !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", ld); end
  endtask

  task automatic test_byte_mask();
    int lat;
    logic [31:0] ld;
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b1111, lat, ld);
    do_req(1'b1, 32'h20, 32'h00000012, 4'b0001, lat, ld);
    do_req(1'b0, 32'h20, 32'h0, 4'b0000, lat, ld);
    checks++; if (ld !== 32'hFFFFFF12) begin errors++; $display("FAIL mask_0001: got %h expected ffffff12", ld); end
    do_req(1'b1, 32'h20, 32'h00000000, 4'b0000, lat, ld);
    checks++; if (lat != LAT) begin errors++; $display("FAIL mask_0000_resp: got %0d expected %0d", lat, LAT); end
    do_req(1'b0, 32'h20, 32'h0, 4'b0000, lat, ld);
    checks++; if (ld !== 32'hFFFFFF12) begin errors++; $display("FAIL mask_0000_nochange: got %h expected ffffff12", ld); end
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b1010, lat, ld);
    do_req(1'b0, 32'h20, 32'h0, 4'b0000, lat, ld);
    checks++; if (ld !== 32'hAAFFCC12) begin errors++; $display("FAIL mask_1010: got %h expected aaffcc12", ld); end
  endtask

  task automatic test_alias();
    int lat;
    logic [31:0] ld;
    do_req(1'b1, 32'h0, 32'h00000005, 4'b1111, lat, ld);
    do_req(1'b0, 32'h1000, 32'h0, 4'b0000, lat, ld);
    checks++; if (ld !== 32'h5) begin errors++; $display("FAIL alias_1000: got %h expected 00000005", ld); end
    do_req(1'b1, 32'h44, 32'h0BADF00D, 4'b1111, lat, ld);
    do_req(1'b0, 32'h3, 32'h0, 4'b0000, lat, ld);
    checks++; if (ld !== 32'h5) begin errors++; $display("FAIL alias_offset3: got %h expected 00000005", ld); end
    repeat (3) @(negedge clk);
    checks++; if (load_data !== 32'h5) begin errors++; $display("FAIL load_data_stable: got %h expected 00000005", load_data); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] ld;
    logic [31:0] a_tab [3];
    logic [31:0] d_tab [3];
    int acc [3];
    int rc [3];
    logic [31:0] rd [3];
    int k;
    int r;
    int busy;
    a_tab[0] = 32'h40; a_tab[1] = 32'h44; a_tab[2] = 32'h48;
    d_tab[0] = 32'h11110000; d_tab[1] = 32'h22220001; d_tab[2] = 32'h33330002;
    for (int i = 0; i < 3; i++) do_req(1'b1, a_tab[i], d_tab[i], 4'b1111, lat, ld);
    for (int i = 0; i < 3; i++) begin acc[i] = -1; rc[i] = -1; rd[i] = 32'd0; end
    k = 0; r = 0; busy = 0;
    cmd = 1'b0; mask = 4'b0000; addr = a_tab[0]; enable = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (valid) begin
        if (r < 3) begin rd[r] = load_data; rc[r] = n; end
        r++;
      end
      if (ready && enable) begin
        if (k < 3) acc[k] = n;
        k++;
      end else if (!ready) begin
        busy++;
      end
      @(negedge clk);
      if (k < 3) addr = a_tab[k];
      else enable = 1'b0;
    end
    enable = 1'b0;
    checks++; if (r != 3) begin errors++; $display("FAIL b2b_resp_count: got %0d expected 3", r); end
    checks++; if (busy != 6) begin errors++; $display("FAIL b2b_ready_low_cycles: got %0d expected 6", busy); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (acc[i] != 3 * i) begin errors++; $display("FAIL b2b_accept_cycle[%0d]: got %0d expected %0d", i, acc[i], 3 * i); end
      checks++; if (rc[i] != 3 * i + 2) begin errors++; $display("FAIL b2b_resp_cycle[%0d]: got %0d expected %0d", i, rc[i], 3 * i + 2); end
      checks++; if (rd[i] !== d_tab[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd[i], d_tab[i]); end
    end
  endtask

  task automatic test_reset_inflight();
    int lat;
    logic [31:0] ld;
    int pulses;
    // Write accepted, then reset during WAIT: the write must survive.
    cmd = 1'b1; addr = 32'h30; write_data = 32'h12345678; mask = 4'b1111; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h30, 32'h0, 4'b0000, lat, ld);
    checks++; if (ld !== 32'h12345678) begin errors++; $display("FAIL reset_keeps_write: got %h expected 12345678", ld); end
    // Read accepted, then reset during WAIT: no response, outputs clear at once.
    cmd = 1'b0; addr = 32'h30; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b expected 1", ready); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", valid); end
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL async_reset_load_data: got %h expected 00000000", load_data); end
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL reset_discards_resp: got %0d valid pulses expected 0", pulses); end
  endtask

`ifdef DATA_MEM_RESPONDER_ERR_CHECK_EN
  task automatic test_err();
    int lat;
    logic [31:0] ld;
    do_req(1'b1, 32'h0, 32'h00000077, 4'b1111, lat, ld);
    do_req(1'b0, 32'h0, 32'h0, 4'b0000, lat, ld);
    checks++; if (last_err !== 1'b0 || ld !== 32'h77) begin errors++; $display("FAIL err_clean_read: got err=%b data=%h expected err=0 data=00000077", last_err, ld); end
    do_req(1'b0, 32'h2, 32'h0, 4'b0000, lat, ld);
    checks++; if (lat != LAT) begin errors++; $display("FAIL err_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (last_err !== 1'b1 || ld !== 32'd0) begin errors++; $display("FAIL err_misaligned: got err=%b data=%h expected err=1 data=00000000", last_err, ld); end
    do_req(1'b1, 32'h1000, 32'hCAFEF00D, 4'b1111, lat, ld);
    checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL err_range_write: got err=%b expected 1", last_err); end
    do_req(1'b0, 32'h0, 32'h0, 4'b0000, lat, ld);
    checks++; if (ld !== 32'h77) begin errors++; $display("FAIL err_write_skipped: got %h expected 00000077", ld); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; last_err = 1'b0;
    rst = 1'b0; enable = 1'b0; cmd = 1'b0; addr = 32'd0; write_data = 32'd0; mask = 4'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_write_read();
    test_byte_mask();
`ifndef DATA_MEM_RESPONDER_ERR_CHECK_EN
    test_alias();
`endif
    test_back_to_back();
    test_reset_inflight();
`ifdef DATA_MEM_RESPONDER_ERR_CHECK_EN
    test_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1, initiator request strobe.
REQ-006 SHALL have port cmd, input, 1, request type: 0 read, 1 write.
REQ-007 SHALL have port addr, input, 32, byte address.
REQ-008 SHALL have port write_data, input, 32, store data.
REQ-009 SHALL have port mask, input, 4, byte enables for writes; bit i covers bits [8i+7:8i].
REQ-010 SHALL have port ready, output, 1, high when a request can be accepted.
REQ-011 SHALL have port valid, output, 1, one-cycle response strobe.
REQ-012 SHALL have port load_data, output, 32, read response data.

Function
REQ-013 SHALL run a state machine with states IDLE, WAIT and RESP; ready SHALL be 1 only in IDLE.
REQ-014 SHALL accept a request at a rising edge where enable=1 and state is IDLE, and SHALL latch cmd, addr, write_data and mask at that edge.
REQ-015 SHALL ignore enable while in WAIT or RESP; there is no queueing and no error indication.
REQ-016 SHALL select the word index from addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] and upper bits SHALL be ignored, so addresses alias modulo DEPTH_WORDS*4.
REQ-017 SHALL commit a write at the acceptance edge, updating only the bytes whose mask bit is 1; mask=0000 SHALL leave memory unchanged but still produce a response.
REQ-018 SHALL count down from the acceptance edge with a 4-bit counter and SHALL enter RESP exactly LATENCY edges after acceptance; with LATENCY=1, WAIT SHALL be skipped.
REQ-019 SHALL hold valid=1 for exactly the one cycle spent in RESP, then return to IDLE.
REQ-020 SHALL drive load_data on a read response with the addressed word as it stands at the RESP-entry edge, including writes committed earlier.
REQ-021 SHALL leave load_data unchanged on a write response, and SHALL hold load_data stable between responses.
REQ-022 SHALL therefore sustain one request per LATENCY+1 cycles when enable is held high.

Reset
REQ-023 SHALL, while rst=0, force state IDLE, ready=1, valid=0, load_data=0 and counter=0, regardless of clk.
REQ-024 SHALL, on reset during WAIT or RESP, discard the in-flight response; a write already committed at acceptance SHALL remain in memory.
REQ-025 SHALL NOT reset the storage array; contents are undefined until written.

Configuration
REQ-026 SHALL, when macro DATA_MEM_RESPONDER_ERR_CHECK_EN is defined, add output port err (1 bit, reset 0) that is valid with valid.
REQ-027 SHALL, with DATA_MEM_RESPONDER_ERR_CHECK_EN defined, flag as errors any request with addr[1:0]!=0 or addr>=DEPTH_WORDS*4.
REQ-028 SHALL, for such a flagged request, skip the array write or read, respond with normal timing, drive err=1 for the valid cycle, and drive load_data=0.
REQ-029 SHALL, without DATA_MEM_RESPONDER_ERR_CHECK_EN, have no err port and follow the aliasing of REQ-016 with no checking.

Verification
REQ-030 SHALL cover the following: with LATENCY=2, write 0xDEADBEEF to 0x10 with mask 1111, then read 0x10 -> the read has valid exactly 2 cycles after acceptance and load_data=0xDEADBEEF.
REQ-031 SHALL cover the following: write 0xFFFFFFFF to 0x20, then write 0x00000012 with mask 0001, then read 0x20 -> load_data=0xFFFFFF12.
REQ-032 SHALL cover the following: with enable held high, issue 3 back-to-back reads -> acceptances 3 cycles apart, ready low during WAIT/RESP, and a second enable while busy is ignored.
REQ-033 SHALL cover the following: with DEPTH_WORDS=1024, write 0x5 to 0x0 then read 0x1000 -> load_data=0x5 (aliasing, macro undefined).
REQ-034 SHALL cover the following: assert rst=0 in the WAIT cycle after a read is accepted -> valid never pulses, ready=1 and load_data=0 immediately, without waiting for a clock edge.
REQ-035 SHALL cover the following: with the macro defined, read 0x2 -> valid with err=1 and load_data=0; a write to 0x1000 leaves word 0 unchanged.
